ssrv_mem_responder: RTL and testbench

- Parametrised successor to the single-cycle harness memory model.
- Serves the core's imem and dmem SCR1-style request/response ports from one shared word array.
- Adds per-port configurable response latency, multiple in-order outstanding requests, LFSR-driven req_ack stall injection, and error responses.
- Sits in the fuzz top between the core and memory, replacing the fixed-latency model.

---
 rtl/ssrv_mem_responder.sv | 197 +++++++++++++++++++
 tb/tb_ssrv_mem_responder.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssrv_mem_responder.sv
// Shared word-array memory model for the imem/dmem request ports.
// Per-port latency, in-order outstanding queue, stall injection, errors.

module ssrv_resp_queue #(
    parameter int          DWIDTH   = 32,
    parameter int          LAT      = 1,
    parameter int          DEPTH    = 4,
    parameter bit          STALL_EN = 1'b0,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [DWIDTH-1:0] push_rdata,
    input  logic              push_err,
    output logic              req_ack,
    output logic              accept,
    output logic [DWIDTH-1:0] rdata,
    output logic [1:0]        resp
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = (LAT > 1) ? $clog2(LAT) : 1;

    logic [15:0]       lfsr_q, lfsr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [DWIDTH-1:0] data_q [DEPTH];
    logic [DWIDTH-1:0] data_d [DEPTH];
    logic              err_q  [DEPTH];
    logic              err_d  [DEPTH];
    logic [TW-1:0]     cd_q   [DEPTH];
    logic [TW-1:0]     cd_d   [DEPTH];
    logic              stall;
    logic              pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Stall source, head presentation, acceptance and queue update
    always_comb begin
        lfsr_d  = {lfsr_q[14:0],
                   lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        stall   = STALL_EN && (lfsr_q[1:0] == 2'b00);
        pop     = (count_q != '0) && (cd_q[head_q] == '0);
        req_ack = !rst && !stall && ((count_q < CW'(DEPTH)) || pop);
        accept  = req && req_ack;
        resp    = pop ? (err_q[head_q] ? 2'd2 : 2'd1) : 2'd0;
        rdata   = pop ? data_q[head_q] : '0;
        data_d  = data_q;
        err_d   = err_q;
        for (int i = 0; i < DEPTH; i++) begin
            cd_d[i] = (cd_q[i] != '0) ? cd_q[i] - TW'(1) : '0;
        end
        if (accept) begin
            data_d[tail_q] = push_rdata;
            err_d[tail_q]  = push_err;
            cd_d[tail_q]   = TW'(LAT - 1);
        end
        head_d  = pop ? nxt(head_q) : head_q;
        tail_d  = accept ? nxt(tail_q) : tail_q;
        count_d = count_q + CW'(accept) - CW'(pop);
    end

    // Control state flushes on reset; payload slots need no reset
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q  <= SEED;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            lfsr_q  <= lfsr_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
        data_q <= data_d;
        err_q  <= err_d;
        cd_q   <= cd_d;
    end
endmodule

module ssrv_mem_responder #(
    parameter int          AWIDTH          = 32,
    parameter int          DWIDTH          = 32,
    parameter int          MEM_WORDS       = 16384,
    parameter int          IMEM_LAT        = 1,
    parameter int          DMEM_LAT        = 1,
    parameter int          MAX_OUTSTANDING = 4,
    parameter bit          STALL_EN        = 1'b0,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    parameter string       INIT_FILE       = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_req,
    input  logic              imem_cmd,
    input  logic [AWIDTH-1:0] imem_addr,
    output logic              imem_req_ack,
    output logic [DWIDTH-1:0] imem_rdata,
    output logic [1:0]        imem_resp,
    input  logic              dmem_req,
    input  logic              dmem_cmd,
    input  logic [1:0]        dmem_width,
    input  logic [AWIDTH-1:0] dmem_addr,
    input  logic [DWIDTH-1:0] dmem_wdata,
    output logic              dmem_req_ack,
    output logic [DWIDTH-1:0] dmem_rdata,
    output logic [1:0]        dmem_resp
);
    localparam int IW = $clog2(MEM_WORDS);
    localparam logic [AWIDTH:0] MEM_BYTES = (AWIDTH + 1)'(MEM_WORDS) << 2;

    logic [DWIDTH-1:0] mem [MEM_WORDS];
    logic [IW-1:0]     i_idx, d_idx;
    logic              i_err, d_err, d_werr;
    logic [3:0]        d_be;
    logic [DWIDTH-1:0] i_rd, d_rd;
    logic              i_acc, d_acc, d_wr;

    // Request decode: error classification, lane enables, read sampling
    always_comb begin
        i_idx  = imem_addr[IW+1:2];
        d_idx  = dmem_addr[IW+1:2];
        i_err  = imem_cmd || ({1'b0, imem_addr} >= MEM_BYTES)
                 || (imem_addr[1:0] != 2'b00);
        d_be   = 4'b0000;
        d_werr = 1'b0;
        unique case (dmem_width)
            2'd0: d_be = 4'b0001 << dmem_addr[1:0];
            2'd1: begin
                d_be   = dmem_addr[1] ? 4'b1100 : 4'b0011;
                d_werr = dmem_addr[0];
            end
            2'd2: begin
                d_be   = 4'b1111;
                d_werr = dmem_addr[1:0] != 2'b00;
            end
            default: d_werr = 1'b1;
        endcase
        d_err = d_werr || ({1'b0, dmem_addr} >= MEM_BYTES);
        i_rd  = i_err ? '0 : mem[i_idx];
        d_rd  = (d_err || dmem_cmd) ? '0 : mem[d_idx];
        d_wr  = d_acc && dmem_cmd && !d_err;
    end

    // Byte-lane write at the acceptance edge; reads above see old data
    always_ff @(posedge clk) begin
        if (d_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (d_be[b]) mem[d_idx][8*b +: 8] <= dmem_wdata[8*b +: 8];
            end
        end
    end

    ssrv_resp_queue #(
        .DWIDTH  (DWIDTH),
        .LAT     (IMEM_LAT),
        .DEPTH   (MAX_OUTSTANDING),
        .STALL_EN(STALL_EN),
        .SEED    (LFSR_SEED)
    ) u_iq (
        .clk       (clk),
        .rst       (rst),
        .req       (imem_req),
        .push_rdata(i_rd),
        .push_err  (i_err),
        .req_ack   (imem_req_ack),
        .accept    (i_acc),
        .rdata     (imem_rdata),
        .resp      (imem_resp)
    );

    ssrv_resp_queue #(
        .DWIDTH  (DWIDTH),
        .LAT     (DMEM_LAT),
        .DEPTH   (MAX_OUTSTANDING),
        .STALL_EN(STALL_EN),
        .SEED    (~LFSR_SEED)
    ) u_dq (
        .clk       (clk),
        .rst       (rst),
        .req       (dmem_req),
        .push_rdata(d_rd),
        .push_err  (d_err),
        .req_ack   (dmem_req_ack),
        .accept    (d_acc),
        .rdata     (dmem_rdata),
        .resp      (dmem_resp)
    );

    logic unused_i_acc;
    assign unused_i_acc = i_acc;
endmodule

// File: tb/tb_ssrv_mem_responder.sv
// Bench for ssrv_mem_responder: directed steps plus a
// cycle-exact response scoreboard over two configurations.

module tb_ssrv_mem_responder;
    localparam int MW = 256;

    typedef struct {
        int          due;
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    logic        rst     [2];
    logic        i_req   [2];
    logic        i_cmd   [2];
    logic [31:0] i_addr  [2];
    logic        i_ack   [2];
    logic [31:0] i_rdata [2];
    logic [1:0]  i_resp  [2];
    logic        d_req   [2];
    logic        d_cmd   [2];
    logic [1:0]  d_width [2];
    logic [31:0] d_addr  [2];
    logic [31:0] d_wdata [2];
    logic        d_ack   [2];
    logic [31:0] d_rdata [2];
    logic [1:0]  d_resp  [2];

    exp_t        sbq [4][$];
    logic [31:0] mdl [2][MW];
    int          n_chk = 0;
    int          n_pass = 0;
    bit          win = 0;
    bit          post = 0;
    int          acc_i = 0;
    int          acc_d = 0;
    int          post_resp = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ssrv_mem_responder #(
        .MEM_WORDS(MW), .IMEM_LAT(3), .DMEM_LAT(4),
        .MAX_OUTSTANDING(2), .STALL_EN(1'b0)
    ) dut (
        .clk(clk), .rst(rst[0]),
        .imem_req(i_req[0]), .imem_cmd(i_cmd[0]), .imem_addr(i_addr[0]),
        .imem_req_ack(i_ack[0]), .imem_rdata(i_rdata[0]),
        .imem_resp(i_resp[0]),
        .dmem_req(d_req[0]), .dmem_cmd(d_cmd[0]), .dmem_width(d_width[0]),
        .dmem_addr(d_addr[0]), .dmem_wdata(d_wdata[0]),
        .dmem_req_ack(d_ack[0]), .dmem_rdata(d_rdata[0]),
        .dmem_resp(d_resp[0])
    );

    ssrv_mem_responder #(
        .MEM_WORDS(MW), .IMEM_LAT(1), .DMEM_LAT(3),
        .MAX_OUTSTANDING(4), .STALL_EN(1'b1)
    ) dut_s (
        .clk(clk), .rst(rst[1]),
        .imem_req(i_req[1]), .imem_cmd(i_cmd[1]), .imem_addr(i_addr[1]),
        .imem_req_ack(i_ack[1]), .imem_rdata(i_rdata[1]),
        .imem_resp(i_resp[1]),
        .dmem_req(d_req[1]), .dmem_cmd(d_cmd[1]), .dmem_width(d_width[1]),
        .dmem_addr(d_addr[1]), .dmem_wdata(d_wdata[1]),
        .dmem_req_ack(d_ack[1]), .dmem_rdata(d_rdata[1]),
        .dmem_resp(d_resp[1])
    );

    function automatic int ilat(int k);
        return (k == 0) ? 3 : 1;
    endfunction

    function automatic int dlat(int k);
        return (k == 0) ? 4 : 3;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic on_resp(int p, logic [1:0] r, logic [31:0] d);
        exp_t e;
        if (r == 2'd0) return;
        if (sbq[p].size() == 0) begin
            check($sformatf("unexpected_resp_p%0d", p), 64'(r), 64'd0);
            return;
        end
        e = sbq[p].pop_front();
        check($sformatf("resp_cycle_p%0d", p), 64'(cyc), 64'(e.due));
        check($sformatf("resp_code_p%0d", p), 64'(r), 64'(e.resp));
        check($sformatf("resp_data_p%0d", p), 64'(d), 64'(e.data));
    endtask

    task automatic imem_model(int k);
        exp_t        e;
        logic [31:0] a = i_addr[k];
        bit          err = i_cmd[k] || (a >= 32'(MW * 4)) || (a[1:0] != 2'b00);
        e.due  = cyc + ilat(k);
        e.resp = err ? 2'd2 : 2'd1;
        e.data = err ? 32'd0 : mdl[k][a[9:2]];
        sbq[2*k].push_back(e);
    endtask

    task automatic dmem_model(int k);
        exp_t        e;
        logic [31:0] a = d_addr[k];
        logic [31:0] w = d_wdata[k];
        bit          ok;
        bit          lane;
        case (d_width[k])
            2'd0:    ok = 1;
            2'd1:    ok = (a[0] == 1'b0);
            2'd2:    ok = (a[1:0] == 2'b00);
            default: ok = 0;
        endcase
        if (a >= 32'(MW * 4)) ok = 0;
        e.due  = cyc + dlat(k);
        e.resp = ok ? 2'd1 : 2'd2;
        e.data = (ok && !d_cmd[k]) ? mdl[k][a[9:2]] : 32'd0;
        if (ok && d_cmd[k]) begin
            for (int b = 0; b < 4; b++) begin
                lane = (d_width[k] == 2'd2)
                    || (d_width[k] == 2'd1 && (b / 2) == int'(a[1]))
                    || (d_width[k] == 2'd0 && b == int'(a[1:0]));
                if (lane) mdl[k][a[9:2]][8*b +: 8] = w[8*b +: 8];
            end
        end
        sbq[2*k+1].push_back(e);
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            on_resp(2 * k, i_resp[k], i_rdata[k]);
            on_resp(2 * k + 1, d_resp[k], d_rdata[k]);
            if (k == 1 && post && (i_resp[1] != 2'd0 || d_resp[1] != 2'd0))
                post_resp++;
            if (i_req[k] && i_ack[k]) imem_model(k);
            if (d_req[k] && d_ack[k]) dmem_model(k);
            if (k == 1 && win) begin
                if (i_req[1] && i_ack[1]) acc_i++;
                if (d_req[1] && d_ack[1]) acc_d++;
            end
            if (rst[k]) begin
                sbq[2*k].delete();
                sbq[2*k+1].delete();
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dreq(bit cmd, logic [1:0] w, logic [31:0] a, logic [31:0] wd);
        bit ok = 0;
        d_req[0] = 1; d_cmd[0] = cmd; d_width[0] = w;
        d_addr[0] = a; d_wdata[0] = wd;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = d_ack[0];
            step();
        end
        d_req[0] = 0;
        if (!ok) check("dreq_timeout", 64'd0, 64'd1);
    endtask

    task automatic ireq(bit cmd, logic [31:0] a);
        bit ok = 0;
        i_req[0] = 1; i_cmd[0] = cmd; i_addr[0] = a;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = i_ack[0];
            step();
        end
        i_req[0] = 0;
        if (!ok) check("ireq_timeout", 64'd0, 64'd1);
    endtask

    task automatic wresp(bit isd, logic [1:0] er, logic [31:0] ed, string tag);
        repeat ((isd ? 4 : 3) - 1) @(posedge clk);
        @(negedge clk);
        check({tag, "_resp"}, 64'(isd ? d_resp[0] : i_resp[0]), 64'(er));
        check({tag, "_data"}, 64'(isd ? d_rdata[0] : i_rdata[0]), 64'(ed));
        step();
    endtask

    task automatic drain();
        bit busy = 1;
        for (int n = 0; n < 100 && busy; n++) begin
            busy = 0;
            for (int p = 0; p < 4; p++) if (sbq[p].size() != 0) busy = 1;
            if (busy) step();
        end
        if (busy) check("drain_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        bit ir[4];
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1; i_req[k] = 0; i_cmd[k] = 0; i_addr[k] = 0;
            d_req[k] = 0; d_cmd[k] = 0; d_width[k] = 0;
            d_addr[k] = 0; d_wdata[k] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_i_ack", 64'(i_ack[0]), 64'd0);
        check("rst_d_ack", 64'(d_ack[0]), 64'd0);
        step();
        rst[0] = 0; rst[1] = 0;
        @(negedge clk);
        check("post_rst_i_resp", 64'(i_resp[0]), 64'd0);
        check("post_rst_i_rdata", 64'(i_rdata[0]), 64'd0);
        check("post_rst_d_resp", 64'(d_resp[0]), 64'd0);
        check("post_rst_d_rdata", 64'(d_rdata[0]), 64'd0);
        check("post_rst_i_ack", 64'(i_ack[0]), 64'd1);
        check("post_rst_d_ack", 64'(d_ack[0]), 64'd1);
        step();

        dreq(1, 2'd2, 32'h10, 32'hDEADBEEF);
        drain();
        ireq(0, 32'h10);
        ir = '{0, 0, 1, 0};
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check($sformatf("imem_lat3_t%0d", n + 1), 64'(i_resp[0]), 64'(ir[n]));
            step();
        end
        check("imem_lat3_none_left", 64'(sbq[0].size()), 64'd0);

        dreq(1, 2'd2, 32'h20, 32'h11223344);
        dreq(1, 2'd0, 32'h21, 32'h0000AA00);
        dreq(0, 2'd2, 32'h20, 32'h0);
        wresp(1, 2'd1, 32'h1122AA44, "byte_merge");
        dreq(1, 2'd1, 32'h21, 32'hFFFFFFFF);
        wresp(1, 2'd2, 32'h0, "hword_misalign");
        dreq(0, 2'd2, 32'h20, 32'h0);
        wresp(1, 2'd1, 32'h1122AA44, "after_misalign");
        dreq(1, 2'd1, 32'h22, 32'h55660000);
        dreq(0, 2'd2, 32'h20, 32'h0);
        wresp(1, 2'd1, 32'h5566AA44, "hword_upper");
        drain();

        d_req[0] = 1; d_cmd[0] = 0; d_width[0] = 2'd2;
        for (int n = 0; n < 8; n++) begin
            d_addr[0] = n[0] ? 32'h20 : 32'h10;
            @(negedge clk);
            check($sformatf("ack_pattern_c%0d", n), 64'(d_ack[0]),
                  64'((n % 4) < 2));
            step();
        end
        d_req[0] = 0;
        drain();

        dreq(0, 2'd2, 32'(MW * 4), 32'h0);
        wresp(1, 2'd2, 32'h0, "dmem_oor");
        ireq(1, 32'h10);
        wresp(0, 2'd2, 32'h0, "imem_wr");
        ireq(0, 32'h10);
        wresp(0, 2'd1, 32'hDEADBEEF, "imem_after_err");
        dreq(0, 2'd3, 32'h20, 32'h0);
        wresp(1, 2'd2, 32'h0, "width_err");
        dreq(0, 2'd2, 32'h22, 32'h0);
        wresp(1, 2'd2, 32'h0, "word_misalign");
        drain();

        i_req[0] = 1; i_cmd[0] = 0; i_addr[0] = 32'h10;
        d_req[0] = 1; d_cmd[0] = 1; d_width[0] = 2'd2;
        d_addr[0] = 32'h10; d_wdata[0] = 32'hCAFEF00D;
        step();
        i_req[0] = 0; d_req[0] = 0;
        wresp(0, 2'd1, 32'hDEADBEEF, "same_cycle_old");
        drain();
        dreq(0, 2'd2, 32'h10, 32'h0);
        wresp(1, 2'd1, 32'hCAFEF00D, "later_read_new");
        drain();

        win = 1;
        for (int n = 0; n < 1000; n++) begin
            i_req[1] = 1; i_cmd[1] = n[1];
            i_addr[1] = n[0] ? 32'(MW * 4) : 32'h3;
            d_req[1] = 1; d_cmd[1] = 1;
            d_width[1] = (n % 7 == 6) ? 2'd3 : 2'd2;
            d_addr[1] = 32'((n % 64) * 4 + ((n % 11 == 10) ? 2 : 0));
            d_wdata[1] = $urandom;
            step();
        end
        win = 0;
        rst[1] = 1; i_req[1] = 0; d_req[1] = 0;
        @(negedge clk);
        check("stall_rst_d_ack", 64'(d_ack[1]), 64'd0);
        step();
        step();
        rst[1] = 0;
        post = 1;
        repeat (10) step();
        post = 0;
        check("resp_after_rst", 64'(post_resp), 64'd0);
        check("imem_ack_rate", 64'(acc_i >= 700 && acc_i <= 800), 64'd1);
        check("dmem_ack_rate", 64'(acc_d >= 700 && acc_d <= 800), 64'd1);

        drain();
        for (int p = 0; p < 4; p++)
            check($sformatf("sb_empty_p%0d", p), 64'(sbq[p].size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
